operand_scoreboard: RTL

//  Decode-stage operand resolver, next generation of the single-operand srcb bypass mux. Resolves NREAD

---
 rtl/operand_scoreboard.sv | 86 ++++++++
 1 files changed

// File: rtl/operand_scoreboard.sv
// operand_scoreboard: resolves decode-stage source operands from forwarding, register file or immediates, stalling on scoreboard hazards
module operand_scoreboard #(
  parameter int XLEN  = 64,
  parameter int NREAD = 2,
  parameter int NFWD  = 3,
  parameter int NREG  = 32,
  parameter int LATW  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NREAD*5-1:0]    ra,
  input  logic [NREAD-1:0]      ra_use,
  input  logic [NREAD*XLEN-1:0] rf_data,
  input  logic [NREAD*XLEN-1:0] imm_data,
  input  logic [4:0]            wa,
  input  logic                  regwrite,
  input  logic [LATW-1:0]       lat,
  input  logic [NFWD-1:0]       fwd_valid,
  input  logic [NFWD*5-1:0]     fwd_wa,
  input  logic [NFWD*XLEN-1:0]  fwd_data,
  input  logic                  wb_valid,
  input  logic [4:0]            wb_wa,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NREAD*XLEN-1:0] src_out
);
  logic [NREG-1:0]       busy;
  logic [LATW-1:0]       cnt [NREG];
  logic [NREAD*XLEN-1:0] res;
  logic [NREAD-1:0]      hz;
  logic                  fire;
  assign in_ready = (!out_valid || out_ready) && !flush && !(|hz);
  assign fire     = in_valid && in_ready;
  // pick each operand's source; youngest matching forward stage wins, unresolved busy registers raise a hazard
  always_comb begin : resolve
    logic [4:0]      a;
    logic            hit;
    logic [XLEN-1:0] fd;
    res = '0;
    hz  = '0;
    for (int i = 0; i < NREAD; i++) begin
      a   = ra[i*5 +: 5];
      hit = 1'b0;
      fd  = '0;
      for (int j = NFWD-1; j >= 0; j--) begin
        if (fwd_valid[j] && fwd_wa[j*5 +: 5] == a) begin
          hit = 1'b1;
          fd  = fwd_data[j*XLEN +: XLEN];
        end
      end
      if (!ra_use[i]) res[i*XLEN +: XLEN] = imm_data[i*XLEN +: XLEN];
      else if (a == 5'd0) res[i*XLEN +: XLEN] = '0;
      else if (hit && (!busy[a] || cnt[a] == '0)) res[i*XLEN +: XLEN] = fd;
      else if (!busy[a]) res[i*XLEN +: XLEN] = rf_data[i*XLEN +: XLEN];
      else hz[i] = 1'b1;
    end
  end
  // scoreboard: countdown every cycle, writeback clears, a same-cycle issue reloads and wins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset || flush) begin
      busy <= '0;
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt[r] <= (cnt[r] == '0) ? '0 : cnt[r] - LATW'(1);
      if (wb_valid && wb_wa != 5'd0) busy[wb_wa] <= 1'b0;
      if (fire && regwrite && wa != 5'd0) begin
        busy[wa] <= 1'b1;
        cnt[wa]  <= lat;
      end
    end
  end
  // registered valid/ready output stage holding operands under backpressure
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      src_out   <= '0;
    end else if (flush) out_valid <= 1'b0;
    else if (fire) begin
      out_valid <= 1'b1;
      src_out   <= res;
    end else if (out_ready) out_valid <= 1'b0;
  end
endmodule
